// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default VGA 640x480 timing constants and RGB332 pixel type
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int PIPE_DELAY_DEF = 2;

  localparam int COORD_W = 11;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Widen to 4 bits per channel by repeating MSBs so full-scale stays full-scale.
  function automatic logic [11:0] expand_rgb332(input rgb332_t c);
    return {c.r, c.r[2], c.g, c.g[2], c.b, c.b};
  endfunction

endpackage

// File: rtl/tick_delay_line.sv
// rtl/tick_delay_line.sv - shift register of configurable width/depth that advances only when en is high
module tick_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, delayed sync/blank and RGB332 to 12-bit DAC drive
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [7:0]         RGBin,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               pixelEn,
  output logic               startOfFrame,
  output logic               hSyncN,
  output logic               vSyncN,
  output logic               blankN,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic               pix_en;
  logic [COORD_W-1:0] hcnt;
  logic [COORD_W-1:0] vcnt;
  logic               hsync_raw;
  logic               vsync_raw;
  logic               visible_raw;
  logic [2:0]         dly_out;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) pix_en <= 1'b0;
    else         pix_en <= ~pix_en;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign hsync_raw   = (hcnt >= H_SYNC_BEG) && (hcnt <= H_SYNC_END);
  assign vsync_raw   = (vcnt >= V_SYNC_BEG) && (vcnt <= V_SYNC_END);
  assign visible_raw = (hcnt < H_VIS) && (vcnt < V_VIS);

  // Delay matches the drawing pipeline latency so RGBin and the timing arrive together.
  tick_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DELAY)
  ) u_delay (
    .clk    (clk),
    .resetN (resetN),
    .en     (pix_en),
    .din    ({visible_raw, vsync_raw, hsync_raw}),
    .dout   (dly_out)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hSyncN <= 1'b1;
      vSyncN <= 1'b1;
      blankN <= 1'b0;
      {red, green, blue} <= 12'h000;
    end else if (pix_en) begin
      hSyncN <= ~dly_out[0];
      vSyncN <= ~dly_out[1];
      blankN <= dly_out[2];
      {red, green, blue} <= dly_out[2] ? expand_rgb332(rgb332_t'(RGBin)) : 12'h000;
    end
  end

  assign pixelEn      = pix_en;
  assign pixelX       = signed'(hcnt);
  assign pixelY       = signed'(vcnt);
  assign startOfFrame = pix_en && (hcnt == '0) && (vcnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic               resetN;
  logic [7:0]         rgb_in;
  logic signed [10:0] px, py;
  logic               pen, sof, hs_n, vs_n, blank_n;
  logic [3:0]         red, green, blue;

  logic               s_resetN;
  logic [7:0]         s_rgb;
  logic signed [10:0] s_px, s_py;
  logic               s_pen, s_sof, s_hs_n, s_vs_n, s_blank_n;
  logic [3:0]         s_red, s_green, s_blue;

  vga_timing_gen dut (
    .clk(clk), .resetN(resetN), .RGBin(rgb_in),
    .pixelX(px), .pixelY(py), .pixelEn(pen), .startOfFrame(sof),
    .hSyncN(hs_n), .vSyncN(vs_n), .blankN(blank_n),
    .red(red), .green(green), .blue(blue)
  );

  // Tiny raster (16x8 total) with no pipeline delay so full frames fit in a short run.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(0)
  ) dut_s (
    .clk(clk), .resetN(s_resetN), .RGBin(s_rgb),
    .pixelX(s_px), .pixelY(s_py), .pixelEn(s_pen), .startOfFrame(s_sof),
    .hSyncN(s_hs_n), .vSyncN(s_vs_n), .blankN(s_blank_n),
    .red(s_red), .green(s_green), .blue(s_blue)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    int n = 0;
    do begin @(negedge clk); n++; end while (!pen && n < 4);
    if (!pen) check("tick_timeout", 32'(pen), 1);
  endtask

  int hlow, first_hlow, nblank, col_err, vs_err;
  int n_nz, al_err, guard;
  logic prev_blank, nz, rise;
  int tidx, vlow, first_v_x, first_v_y, first_h, sof_clks, sof0, sof1, n_sof;

  initial begin
    resetN = 1'b0; s_resetN = 1'b0; rgb_in = 8'hE3; s_rgb = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_x", 32'(px), 0);
    check("rst_y", 32'(py), 0);
    check("rst_pen", 32'(pen), 0);
    check("rst_sof", 32'(sof), 0);
    check("rst_hs", 32'(hs_n), 1);
    check("rst_vs", 32'(vs_n), 1);
    check("rst_blank", 32'(blank_n), 0);
    check("rst_rgb", 32'({red, green, blue}), 0);

    resetN = 1'b1;
    @(negedge clk);
    check("first_pen", 32'(pen), 1);
    check("first_x", 32'(px), 0);
    check("first_y", 32'(py), 0);
    check("first_sof", 32'(sof), 1);
    check("first_hs", 32'(hs_n), 1);
    @(negedge clk);
    check("second_pen", 32'(pen), 0);
    check("sof_one_clk", 32'(sof), 0);
    check("x_after_tick", 32'(px), 1);

    // Line timing and constant-colour path, ticks 1..899
    hlow = 0; first_hlow = -1; nblank = 0; col_err = 0; vs_err = 0;
    for (int k = 1; k < 900; k++) begin
      next_tick();
      if (k == 3) begin
        check("blank_first_vis", 32'(blank_n), 1);
        check("rgb_first_vis", 32'({red, green, blue}), 32'h0F0F);
      end
      if (k == 799) begin
        check("x_at_799", 32'(px), 799);
        check("y_line0", 32'(py), 0);
      end
      if (k == 800) begin
        check("x_wrap", 32'(px), 0);
        check("y_inc", 32'(py), 1);
      end
      if (k < 800) begin
        if (!hs_n) begin
          hlow++;
          if (first_hlow < 0) first_hlow = int'(px);
        end
        if (blank_n) nblank++;
      end
      if (!vs_n) vs_err++;
      if ({red, green, blue} !== (blank_n ? 12'hF0F : 12'h000)) col_err++;
    end
    check("hsync_width", 32'(hlow), 96);
    check("hsync_start_x", 32'(first_hlow), 659);
    check("visible_ticks", 32'(nblank), 640);
    check("colour_errs", 32'(col_err), 0);
    check("vsync_line0_1", 32'(vs_err), 0);

    // Alignment: RGBin=FF only for sampled pixel 0, lines 2..4
    guard = 0;
    while (!(px == 799 && py == 1) && guard < 2000) begin next_tick(); guard++; end
    check("align_start_y", 32'(py), 1);
    rgb_in = 8'h00;
    prev_blank = 1'b0; n_nz = 0; al_err = 0;
    for (int k = 0; k < 2400; k++) begin
      next_tick();
      nz = |{red, green, blue};
      rise = blank_n && !prev_blank;
      if (nz !== rise) al_err++;
      if (nz) n_nz++;
      prev_blank = blank_n;
      rgb_in = (px == 2) ? 8'hFF : 8'h00;
    end
    check("align_nonzero_lines", 32'(n_nz), 3);
    check("align_errs", 32'(al_err), 0);

    // Mid-frame reset while hSync is being driven
    guard = 0;
    while (px != 700 && guard < 1000) begin next_tick(); guard++; end
    check("pre_reset_hs", 32'(hs_n), 0);
    #2 resetN = 1'b0;
    #1;
    check("async_x", 32'(px), 0);
    check("async_y", 32'(py), 0);
    check("async_pen", 32'(pen), 0);
    check("async_hs", 32'(hs_n), 1);
    check("async_sof", 32'(sof), 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("restart_sof", 32'(sof), 1);
    check("restart_x", 32'(px), 0);
    check("restart_y", 32'(py), 0);
    hlow = 0; first_hlow = -1; vs_err = 0;
    for (int k = 1; k < 800; k++) begin
      next_tick();
      if (!hs_n) begin
        hlow++;
        if (first_hlow < 0) first_hlow = int'(px);
      end
      if (!vs_n) vs_err++;
    end
    check("restart_hsync_width", 32'(hlow), 96);
    check("restart_hsync_start", 32'(first_hlow), 659);
    check("restart_vsync", 32'(vs_err), 0);

    // Small raster, zero pipeline delay: frame period, vsync width, one-tick lag
    @(negedge clk);
    s_resetN = 1'b1;
    tidx = 0; vlow = 0; first_v_x = -1; first_v_y = -1; first_h = -1;
    sof_clks = 0; sof0 = -1; sof1 = -1; n_sof = 0;
    for (int c = 0; c < 600 && tidx < 200; c++) begin
      @(negedge clk);
      if (s_sof) sof_clks++;
      if (s_pen) begin
        if (s_sof) begin
          if (n_sof == 0) sof0 = tidx;
          else if (n_sof == 1) sof1 = tidx;
          n_sof++;
        end
        if (tidx < 128 && !s_vs_n) begin
          vlow++;
          if (first_v_y < 0) begin first_v_y = int'(s_py); first_v_x = int'(s_px); end
        end
        if (tidx < 16 && !s_hs_n && first_h < 0) first_h = int'(s_px);
        tidx++;
      end
    end
    check("s_ticks_run", 32'(tidx), 200);
    check("s_sof_first_tick", 32'(sof0), 0);
    check("s_frame_period", 32'(sof1 - sof0), 128);
    check("s_sof_clks", 32'(sof_clks), 2);
    check("s_vsync_width", 32'(vlow), 32);
    check("s_vsync_start_y", 32'(first_v_y), 5);
    check("s_vsync_start_x", 32'(first_v_x), 1);
    check("s_hsync_lag", 32'(first_h), 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 The module SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 The module SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-005 The module SHALL have parameters V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_BACK=33, meaning the vertical equivalents, in lines.
REQ-006 The module SHALL have parameter PIPE_DELAY, default 2, range 0..4, meaning the pixel-enable ticks between coordinate output and RGBin validity.
REQ-007 Port clk, input, 1 bit: the single system clock, 50 MHz.
REQ-008 Port resetN, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port RGBin, input, 8 bits: pixel colour from the drawing mux, RRRGGGBB.
REQ-010 Port pixelX, output, signed 11 bits: current column.
REQ-011 Port pixelY, output, signed 11 bits: current row.
REQ-012 Port pixelEn, output, 1 bit: pixel-rate strobe, high every second clk.
REQ-013 Port startOfFrame, output, 1 bit: one-clk pulse at the first pixel of each frame.
REQ-014 Ports hSyncN and vSyncN, outputs, 1 bit each: active-low sync.
REQ-015 Port blankN, output, 1 bit: high when the delayed pixel is visible.
REQ-016 Ports red, green and blue, outputs, 4 bits each: VGA DAC drive.

Function
REQ-017 pixelEn SHALL toggle each clk, so a tick occurs on alternate clocks.
REQ-018 pixelX SHALL increment by 1 on each tick and wrap from H_TOTAL-1 to 0, where H_TOTAL = sum of the H parameters (800).
REQ-019 pixelY SHALL increment only on a tick where pixelX wraps, and SHALL wrap from V_TOTAL-1 (524) to 0.
REQ-020 pixelX and pixelY SHALL keep counting through blanking (640..799, 480..524) and SHALL never be negative.
REQ-021 startOfFrame SHALL be high for exactly one clk, coincident with the tick on which (pixelX,pixelY) becomes (0,0).
REQ-022 Raw hSync SHALL be active for pixelX in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751].
REQ-023 Raw vSync SHALL be active for pixelY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490,491].
REQ-024 Raw visible SHALL be defined as pixelX < H_VISIBLE and pixelY < V_VISIBLE.
REQ-025 Raw hSync, vSync and visible SHALL pass through a PIPE_DELAY-stage shift register that advances on ticks only, then one output register.
REQ-026 RGBin SHALL be sampled on the same tick as the last delay stage.
REQ-027 red/green/blue SHALL be {RRR,R}, {GGG,G} and {BB,BB} when blankN=1, and 0 otherwise.
REQ-028 hSyncN, vSyncN, blankN and the colour outputs SHALL change only on ticks and SHALL remain mutually aligned.
REQ-029 With PIPE_DELAY=0, sync and blank SHALL lag the coordinates by exactly one tick (the output register).

Reset
REQ-030 While resetN=0, pixelX=0, pixelY=0, pixelEn=0, startOfFrame=0, hSyncN=1, vSyncN=1, blankN=0, RGB=0, and all delay stages SHALL hold inactive values.
REQ-031 The first tick after release SHALL be on the second clk edge, and SHALL present (0,0) with a startOfFrame pulse.
REQ-032 Reset asserted mid-frame SHALL force outputs to reset values immediately (asynchronously), with no partial sync pulse after release.

Structure
REQ-033 The default timing constants and the RGB332 typedef SHALL reside in shared package vga_pkg.
REQ-034 The delay line SHALL be a sub-module, tick_delay_line (width and depth parameterised, advance-on-enable).

Verification
REQ-035 Reset release: pixelEn first high on clk 2, pixelX=0, pixelY=0, startOfFrame=1 for one clk, hSyncN=1.
REQ-036 Line timing: ticks 0..799 -> pixelX wraps 799->0, pixelY 0->1, and hSyncN low for exactly 96 ticks starting at pixelX=656+PIPE_DELAY+1.
REQ-037 Frame timing: run 800*525 ticks -> vSyncN low for exactly 1600 ticks, and the next startOfFrame arrives exactly 420000 ticks after the first.
REQ-038 Colour path: RGBin=8'hE3 constant -> red=4'hF, green=0, blue=4'hF while blankN=1, and all colours are 0 during blanking.
REQ-039 Alignment: RGBin=8'hFF only when the sampled pixelX<1 -> non-zero colour appears on exactly the first blankN=1 tick of each line.
REQ-040 Mid-frame reset at pixelY=300: outputs are immediately at reset values, and after release the counters restart at (0,0) with no spurious sync pulse.
